// File: rtl/mcc_pkg.sv
// +------------------------------------------------------------------+
// | mcc_pkg : shared opcode constants and FSM state type for the     |
// |           multi-cycle controller.   Rev 1.0                      |
// +------------------------------------------------------------------+
`default_nettype none

package mcc_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [1:0] OP_MOV   = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mcc_opcode_decode.sv
// +------------------------------------------------------------------+
// | mcc_opcode_decode : one-hot classification of the 2-bit opcode.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mcc_opcode_decode
  import mcc_pkg::*;
(
  input  logic [1:0] op,
  output logic       is_mov,
  output logic       is_shift,
  output logic       is_jump,
  output logic       is_rsvd
);

  assign is_mov   = (op == OP_MOV);
  assign is_shift = (op == OP_SHIFT);
  assign is_jump  = (op == OP_JUMP);
  assign is_rsvd  = (op == OP_RSVD);

endmodule

`default_nettype wire

// File: rtl/multi_cycle_controller.sv
// +------------------------------------------------------------------+
// | multi_cycle_controller : FETCH/DECODE/EXECUTE/WRITEBACK sequencer |
// | with retired-instruction counter. Optional MCC_SINGLE_STEP_EN     |
// | adds step_req/halted single-step control.   Rev 1.0              |
// +------------------------------------------------------------------+
`default_nettype none

module multi_cycle_controller
  import mcc_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             imem_ready,
  input  logic [1:0]       opcode,
  input  logic             stall,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             jump,
  output logic             RegWrite,
  output logic             SMCtrl,
  output logic             illegal_op,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired
`ifdef MCC_SINGLE_STEP_EN
  ,
  input  logic             step_req,
  output logic             halted
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     cur;
  logic [1:0] op_q;
  logic [1:0] dec_op;
  logic       is_mov, is_shift, is_jump, is_rsvd;
  logic       pcw_q, jmp_q, rw_q, ill_q, sm_q;
  logic       go;

  // The live opcode is classified only in DECODE; elsewhere the registered copy steers.
  assign dec_op = (cur == DECODE) ? opcode : op_q;

  mcc_opcode_decode u_dec (
    .op       (dec_op),
    .is_mov   (is_mov),
    .is_shift (is_shift),
    .is_jump  (is_jump),
    .is_rsvd  (is_rsvd)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cur     <= FETCH;
      op_q    <= OP_MOV;
      pcw_q   <= 1'b0;
      jmp_q   <= 1'b0;
      rw_q    <= 1'b0;
      ill_q   <= 1'b0;
      sm_q    <= 1'b0;
      retired <= '0;
    end else if (!stall) begin
      case (cur)
        FETCH: begin
          if (imem_ready && go) cur <= DECODE;
        end
        DECODE: begin
          op_q  <= opcode;
          sm_q  <= is_mov;
          pcw_q <= is_jump | is_rsvd;
          jmp_q <= is_jump;
          ill_q <= is_rsvd;
          cur   <= EXECUTE;
        end
        EXECUTE: begin
          jmp_q <= 1'b0;
          ill_q <= 1'b0;
          if (is_jump) begin
            pcw_q   <= 1'b0;
            retired <= retired + CNT_ONE;
            cur     <= FETCH;
          end else if (is_rsvd) begin
            pcw_q <= 1'b0;
            cur   <= FETCH;
          end else if (is_mov || is_shift) begin
            pcw_q <= 1'b1;
            rw_q  <= 1'b1;
            cur   <= WRITEBACK;
          end else begin
            cur <= FETCH;
          end
        end
        WRITEBACK: begin
          pcw_q   <= 1'b0;
          rw_q    <= 1'b0;
          sm_q    <= 1'b0;
          retired <= retired + CNT_ONE;
          cur     <= FETCH;
        end
        default: cur <= FETCH;
      endcase
    end
  end

`ifdef MCC_SINGLE_STEP_EN
  logic halted_q;

  // Halt after every completed or trapped instruction; a step request re-arms FETCH.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      halted_q <= 1'b0;
    end else if (!stall) begin
      if (cur == WRITEBACK || (cur == EXECUTE && (is_jump || is_rsvd))) begin
        halted_q <= 1'b1;
      end else if (cur == FETCH && step_req) begin
        halted_q <= 1'b0;
      end
    end
  end

  assign halted = halted_q;
  assign go     = ~halted_q;
`else
  assign go = 1'b1;
`endif

  // IRWrite follows imem_ready combinationally, so it must also be masked by reset.
  assign IRWrite    = Reset & (cur == FETCH) & imem_ready & go & ~stall;
  assign PCWrite    = pcw_q & ~stall;
  assign jump       = jmp_q & ~stall;
  assign RegWrite   = rw_q  & ~stall;
  assign illegal_op = ill_q & ~stall;
  assign SMCtrl     = sm_q;
  assign state      = cur;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
// +------------------------------------------------------------------+
// | tb_multi_cycle_controller : scoreboard bench for the controller. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_multi_cycle_controller;

  logic       Clk;
  logic       Reset;
  logic       imem_ready;
  logic [1:0] opcode;
  logic       stall;
  logic       IRWrite, PCWrite, jump, RegWrite, SMCtrl, illegal_op;
  logic [1:0] state;
  logic [3:0] retired;
`ifdef MCC_SINGLE_STEP_EN
  logic       step_req;
  logic       halted;
  logic       exp_halt;
`endif

  multi_cycle_controller #(.CNT_W(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .imem_ready (imem_ready),
    .opcode     (opcode),
    .stall      (stall),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .jump       (jump),
    .RegWrite   (RegWrite),
    .SMCtrl     (SMCtrl),
    .illegal_op (illegal_op),
    .state      (state),
    .retired    (retired)
`ifdef MCC_SINGLE_STEP_EN
    ,
    .step_req   (step_req),
    .halted     (halted)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         lat;
    logic       rw;
    logic       jmp;
    logic       ill;
    logic       sm;
    logic [3:0] ret;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur_e;
  int         n_chk    = 0;
  int         n_bad    = 0;
  int         cyc      = 0;
  int         start_cyc = 0;
  int         done_cnt = 0;
  bit         post_pend = 0;
  logic [3:0] post_ret;
  logic [3:0] model_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Completion monitor: pops the scoreboard on each end-of-instruction PCWrite.
  always @(negedge Clk) begin
    if (Reset) begin
      cyc++;
      if (post_pend) begin
        check("ret", {28'd0, retired}, {28'd0, post_ret});
        check("post_state", {30'd0, state}, 32'd0);
        check("post_strb", {29'd0, illegal_op, PCWrite, RegWrite}, 32'd0);
        post_pend = 0;
        done_cnt++;
      end
      if (IRWrite) begin
        check("ir_state", {30'd0, state}, 32'd0);
        start_cyc = cyc;
      end
      if (RegWrite) check("rw_state", {30'd0, state}, 32'd3);
      if (PCWrite) begin
        if (exp_q.size() == 0) begin
          check("unexp_end", 32'd1, 32'd0);
        end else begin
          cur_e = exp_q.pop_front();
          check("lat", cyc - start_cyc + 1, cur_e.lat);
          check("rw", {31'd0, RegWrite}, {31'd0, cur_e.rw});
          check("jmp", {31'd0, jump}, {31'd0, cur_e.jmp});
          check("ill", {31'd0, illegal_op}, {31'd0, cur_e.ill});
          check("sm", {31'd0, SMCtrl}, {31'd0, cur_e.sm});
          post_ret  = cur_e.ret;
          post_pend = 1;
        end
      end
    end
  end

  task automatic release_fetch();
`ifdef MCC_SINGLE_STEP_EN
    check("halted", {31'd0, halted}, {31'd0, exp_halt});
    if (exp_halt) begin
      imem_ready = 1'b1;
      #1;
      check("ir_supp", {31'd0, IRWrite}, 32'd0);
      step_req = 1'b1;
      @(posedge Clk); #1;
      step_req = 1'b0;
      exp_halt = 1'b0;
    end
`endif
  endtask

  task automatic issue(input logic [1:0] op, input int stall_n);
    exp_t e;
    int   prev;
    bit   ok;
    release_fetch();
    e.lat = ((op == 2'b11 || op == 2'b10) ? 3 : 4) + stall_n;
    e.rw  = (op == 2'b00 || op == 2'b01);
    e.jmp = (op == 2'b11);
    e.ill = (op == 2'b10);
    e.sm  = (op == 2'b00);
    if (op != 2'b10) model_ret = model_ret + 4'd1;
    e.ret = model_ret;
    exp_q.push_back(e);
    prev       = done_cnt;
    opcode     = op;
    imem_ready = 1'b1;
    @(posedge Clk); #1;
    imem_ready = 1'b0;
    @(posedge Clk); #1;
    opcode = 2'($urandom);
    if (stall_n > 0) begin
      stall = 1'b1;
      for (int i = 0; i < stall_n; i++) begin
        @(negedge Clk);
        check("stl_state", {30'd0, state}, 32'd2);
        check("stl_strb", {27'd0, IRWrite, PCWrite, RegWrite, illegal_op, jump}, 32'd0);
        @(posedge Clk); #1;
      end
      stall = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge Clk); #1;
      if (done_cnt != prev) ok = 1;
    end
    if (!ok) begin
      check("timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
`ifdef MCC_SINGLE_STEP_EN
    exp_halt = 1'b1;
`endif
  endtask

  task automatic reset_in_wb();
    release_fetch();
    opcode     = 2'b00;
    imem_ready = 1'b1;
    @(posedge Clk); #1;
    imem_ready = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("wb_state", {30'd0, state}, 32'd3);
    check("wb_rw", {31'd0, RegWrite}, 32'd1);
    check("wb_sm", {31'd0, SMCtrl}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("arst_strb", {28'd0, RegWrite, PCWrite, SMCtrl, IRWrite}, 32'd0);
    check("arst_state", {30'd0, state}, 32'd0);
    check("arst_ret", {28'd0, retired}, 32'd0);
    model_ret = 4'd0;
`ifdef MCC_SINGLE_STEP_EN
    exp_halt = 1'b0;
`endif
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("arst_fetch", {30'd0, state}, 32'd0);
  endtask

  initial begin
    Reset      = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b1;
    opcode     = 2'b00;
    model_ret  = 4'd0;
`ifdef MCC_SINGLE_STEP_EN
    step_req = 1'b0;
    exp_halt = 1'b0;
`endif
    repeat (2) @(posedge Clk);
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_ret", {28'd0, retired}, 32'd0);
    check("rst_strb", {26'd0, IRWrite, PCWrite, RegWrite, illegal_op, jump, SMCtrl}, 32'd0);
    imem_ready = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("rel_state", {30'd0, state}, 32'd0);

    issue(2'b00, 0);
    issue(2'b11, 0);
    issue(2'b10, 0);
    issue(2'b01, 0);
    issue(2'b01, 5);
    issue(2'b11, 2);
    issue(2'b00, 1);
    issue(2'b10, 3);

    reset_in_wb();

    for (int k = 0; k < 16; k++) issue(2'b00, 0);
    check("wrap", {28'd0, retired}, 32'd0);
    check("q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port imem_ready, input, 1 bit: the instruction word is valid this cycle.
REQ-005 The block SHALL have port opcode, input, 2 bits: instruction register bits [7:6].
REQ-006 The block SHALL have port stall, input, 1 bit: freezes sequencing.
REQ-007 The block SHALL have port IRWrite, output, 1 bit: load the instruction register.
REQ-008 The block SHALL have port PCWrite, output, 1 bit: update the PC.
REQ-009 The block SHALL have port jump, output, 1 bit: PC source is PC plus the sign-extended offset, not PC+1.
REQ-010 The block SHALL have port RegWrite, output, 1 bit: register-file write enable.
REQ-011 The block SHALL have port SMCtrl, output, 1 bit: writeback select, 1 = mov, 0 = shift.
REQ-012 The block SHALL have port illegal_op, output, 1 bit: one-cycle pulse on a reserved opcode.
REQ-013 The block SHALL have port state, output, 2 bits: the current FSM state.
REQ-014 The block SHALL have port retired, output, CNT_W bits: count of completed instructions.

Function
REQ-015 Opcode encoding SHALL be: 00 = mov, 01 = shift, 10 = reserved, 11 = jump.
REQ-016 FSM states SHALL be FETCH = 0, DECODE = 1, EXECUTE = 2, WRITEBACK = 3.
REQ-017 In FETCH, when imem_ready = 1, the block SHALL assert IRWrite for that cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-018 In DECODE, the block SHALL register the opcode and go to EXECUTE unconditionally.
REQ-019 In EXECUTE with a registered jump opcode, the block SHALL assert PCWrite and jump for one cycle, return to FETCH and increment retired.
REQ-020 In EXECUTE with mov or shift, the block SHALL drive SMCtrl from the registered opcode (mov = 1) and go to WRITEBACK.
REQ-021 In EXECUTE with the reserved opcode, the block SHALL pulse illegal_op, assert PCWrite with jump = 0, return to FETCH and SHALL NOT increment retired.
REQ-022 In WRITEBACK, the block SHALL assert RegWrite and PCWrite (jump = 0) for one cycle, hold SMCtrl, increment retired and return to FETCH.
REQ-023 Latency with imem_ready held high SHALL be 4 cycles for mov and shift, and 3 cycles for jump and reserved.
REQ-024 While stall = 1, the state, the registered opcode and retired SHALL hold, and IRWrite, PCWrite, RegWrite and illegal_op SHALL be 0; stall SHALL take priority over imem_ready.
REQ-025 IRWrite, PCWrite, RegWrite and illegal_op SHALL be mutually consistent: RegWrite is never asserted outside WRITEBACK, and IRWrite is never asserted outside FETCH.
REQ-026 retired SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-027 The opcode input SHALL be sampled only in DECODE; changes in other states SHALL have no effect.

Reset
REQ-028 Reset = 0 SHALL immediately force state = FETCH, registered opcode = 00, retired = 0, and all strobes and SMCtrl to 0, including mid-instruction; no partial write SHALL complete.
REQ-029 The first FETCH after reset deassertion SHALL be in the first rising edge with Reset = 1.

Configuration
REQ-030 With MCC_SINGLE_STEP_EN defined, the block SHALL add input step_req (1 bit) and output halted (1 bit); after each retire or illegal op, the FSM SHALL hold in FETCH with halted = 1 and IRWrite suppressed until a step_req pulse is seen, which releases exactly one instruction.
REQ-031 Without MCC_SINGLE_STEP_EN, step_req and halted SHALL NOT exist and sequencing SHALL be free-running.

Structure
REQ-032 The opcode constants, state encoding and state typedef SHALL live in shared package mcc_pkg.
REQ-033 Opcode classification SHALL be a single sub-module, mcc_opcode_decode (combinational, outputs is_mov, is_shift, is_jump, is_rsvd); all sequencing SHALL stay in multi_cycle_controller.

Verification
REQ-034 Scenario: reset released, imem_ready = 1, opcode = 00 -> states 0,1,2,3; RegWrite = 1 and SMCtrl = 1 at cycle 4; retired = 1.
REQ-035 Scenario: opcode = 11 with imem_ready = 1 -> PCWrite = 1 and jump = 1 at cycle 3, RegWrite never asserted, retired = 1.
REQ-036 Scenario: opcode = 10 -> illegal_op one-cycle pulse at cycle 3, retired unchanged, next state FETCH.
REQ-037 Scenario: stall = 1 for 5 cycles during EXECUTE of a shift -> state holds at 2 with all strobes 0; WRITEBACK occurs 1 cycle after stall drops, SMCtrl = 0.
REQ-038 Scenario: Reset pulled low during WRITEBACK, asynchronously to Clk -> RegWrite drops at once, state = 0, retired = 0.
REQ-039 Scenario: CNT_W = 4, 16 mov instructions -> retired wraps to 0; with MCC_SINGLE_STEP_EN, halted = 1 between instructions until step_req is pulsed.
